// File: rtl/fp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_pkg                                                               |
// | Shared constants and helpers for the pipelined float add/sub block.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fp_pkg;

    localparam int FLG_INVALID = 3;
    localparam int FLG_OVF     = 2;
    localparam int FLG_UNF     = 1;
    localparam int FLG_INEXACT = 0;
    localparam int FLAGS_W     = 4;

    localparam int GRS_W       = 3;
    localparam int MAX_WORD_W  = 64;
    localparam int DEF_EXP_W   = 8;
    localparam int DEF_MAN_W   = 23;
    localparam int DEF_WORD_W  = 1 + DEF_EXP_W + DEF_MAN_W;

    function automatic int word_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all-ones, only the fraction MSB set.
    function automatic logic [MAX_WORD_W-1:0] fp_qnan(input int exp_w, input int man_w);
        logic [MAX_WORD_W-1:0] q;
        q = '0;
        for (int i = 0; i < exp_w; i++) begin
            q[man_w+i] = 1'b1;
        end
        q[man_w-1] = 1'b1;
        return q;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_addsub_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_addsub_pipe_if                                                    |
// | Operand issue / result writeback handshake bundle.                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface fp_addsub_pipe_if
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int c_w = 1 + EXP_W + MAN_W;

    logic               in_valid;
    logic               in_ready;
    logic [c_w-1:0]     a;
    logic [c_w-1:0]     b;
    logic               sub;
    logic               out_valid;
    logic               out_ready;
    logic [c_w-1:0]     result;
    logic [FLAGS_W-1:0] flags;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, flags
    );

endinterface
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_lzc                                                               |
// | Combinational leading-zero counter; all-zero input returns N.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fp_lzc
    import fp_pkg::*;
#(
    parameter int N = 28
) (
    input  logic [N-1:0]               i_data,
    output logic [$clog2(N+1)-1:0]     o_count
);
    localparam int c_cw = $clog2(N + 1);

    // Later (higher) hits override earlier ones, so the MSB-most one wins.
    always_comb begin
        o_count = c_cw'(N);
        for (int i = 0; i < N; i++) begin
            if (i_data[i]) begin
                o_count = c_cw'(N - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_addsub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_addsub_pipe                                                       |
// | 3-stage float adder/subtractor: align, add+LZC, normalise/round/pack.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic            clk,
    input  logic            rst_n,
    fp_addsub_pipe_if.slave bus
);
    localparam int c_w     = word_w(EXP_W, MAN_W);
    localparam int c_mw    = MAN_W + 1 + GRS_W;
    localparam int c_sw    = c_mw + 1;
    localparam int c_lw    = $clog2(c_sw + 1);
    localparam int c_xw    = ((EXP_W > c_lw) ? EXP_W : c_lw) + 2;
    localparam int c_shmax = MAN_W + 3;
    localparam logic [EXP_W-1:0] c_emax = '1;
    localparam logic [c_mw-1:0]  c_ones = '1;
    localparam logic [c_w-1:0]   c_qnan = c_w'(fp_qnan(EXP_W, MAN_W));

    logic w_en;
    assign w_en         = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = w_en;

    // ---------------- S1: unpack, specials, swap, align ----------------
    logic             w_sa, w_sb;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb, w_fa_z, w_fb_z;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_spec, w_swap;
    assign w_sa    = bus.a[c_w-1];
    assign w_sb    = bus.b[c_w-1] ^ bus.sub;
    assign w_ea    = bus.a[c_w-2:MAN_W];
    assign w_eb    = bus.b[c_w-2:MAN_W];
    assign w_fa    = bus.a[MAN_W-1:0];
    assign w_fb    = bus.b[MAN_W-1:0];
    assign w_fa_z  = (w_ea == '0) ? '0 : w_fa;
    assign w_fb_z  = (w_eb == '0) ? '0 : w_fb;
    assign w_a_nan = (w_ea == c_emax) & (|w_fa);
    assign w_b_nan = (w_eb == c_emax) & (|w_fb);
    assign w_a_inf = (w_ea == c_emax) & ~(|w_fa);
    assign w_b_inf = (w_eb == c_emax) & ~(|w_fb);
    assign w_spec  = w_a_nan | w_b_nan | w_a_inf | w_b_inf;
    assign w_swap  = {w_eb, w_fb_z} > {w_ea, w_fa_z};

    logic [c_w-1:0]     w_spec_res;
    logic [FLAGS_W-1:0] w_spec_flg;
    always_comb begin
        w_spec_res = c_qnan;
        w_spec_flg = '0;
        if (w_a_nan | w_b_nan) begin
            w_spec_res = c_qnan;
        end else if (w_a_inf & w_b_inf & (w_sa != w_sb)) begin
            w_spec_flg[FLG_INVALID] = 1'b1;
        end else if (w_a_inf) begin
            w_spec_res = {w_sa, c_emax, {MAN_W{1'b0}}};
        end else begin
            w_spec_res = {w_sb, c_emax, {MAN_W{1'b0}}};
        end
    end

    logic             w_sbig;
    logic [EXP_W-1:0] w_ebig, w_esml, w_diff;
    logic [MAN_W-1:0] w_fbig, w_fsml;
    logic [c_mw-1:0]  w_mbig, w_msml, w_shifted, w_malign;
    logic [c_lw-1:0]  w_shamt;
    logic             w_lost;
    assign w_sbig    = w_swap ? w_sb : w_sa;
    assign w_ebig    = w_swap ? w_eb : w_ea;
    assign w_esml    = w_swap ? w_ea : w_eb;
    assign w_fbig    = w_swap ? w_fb_z : w_fa_z;
    assign w_fsml    = w_swap ? w_fa_z : w_fb_z;
    assign w_mbig    = {(w_ebig != '0), w_fbig, {GRS_W{1'b0}}};
    assign w_msml    = {(w_esml != '0), w_fsml, {GRS_W{1'b0}}};
    assign w_diff    = w_ebig - w_esml;
    assign w_shamt   = (32'(w_diff) > 32'(c_shmax)) ? c_lw'(c_shmax) : c_lw'(w_diff);
    assign w_shifted = w_msml >> w_shamt;
    assign w_lost    = |(w_msml & ~(c_ones << w_shamt));
    assign w_malign  = {w_shifted[c_mw-1:1], w_shifted[0] | w_lost};

    logic               r1_valid, r1_spec, r1_sign, r1_zsign, r1_esub;
    logic [c_w-1:0]     r1_spec_res;
    logic [FLAGS_W-1:0] r1_spec_flg;
    logic [EXP_W-1:0]   r1_exp;
    logic [c_mw-1:0]    r1_mbig, r1_msml;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid    <= 1'b0;
            r1_spec     <= 1'b0;
            r1_sign     <= 1'b0;
            r1_zsign    <= 1'b0;
            r1_esub     <= 1'b0;
            r1_spec_res <= '0;
            r1_spec_flg <= '0;
            r1_exp      <= '0;
            r1_mbig     <= '0;
            r1_msml     <= '0;
        end else if (w_en) begin
            r1_valid    <= bus.in_valid;
            r1_spec     <= w_spec;
            r1_sign     <= w_sbig;
            r1_zsign    <= w_sa & w_sb;
            r1_esub     <= w_sa ^ w_sb;
            r1_spec_res <= w_spec_res;
            r1_spec_flg <= w_spec_flg;
            r1_exp      <= w_ebig;
            r1_mbig     <= w_mbig;
            r1_msml     <= w_malign;
        end
    end

    // ---------------- S2: add/subtract, leading-zero count ----------------
    logic [c_sw-1:0] w_sum;
    logic [c_lw-1:0] w_lzc;
    assign w_sum = r1_esub ? ({1'b0, r1_mbig} - {1'b0, r1_msml})
                           : ({1'b0, r1_mbig} + {1'b0, r1_msml});

    fp_lzc #(.N(c_sw)) u_lzc (
        .i_data  (w_sum),
        .o_count (w_lzc)
    );

    logic               r2_valid, r2_spec, r2_sign, r2_zsign;
    logic [c_w-1:0]     r2_spec_res;
    logic [FLAGS_W-1:0] r2_spec_flg;
    logic [EXP_W-1:0]   r2_exp;
    logic [c_sw-1:0]    r2_sum;
    logic [c_lw-1:0]    r2_lzc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid    <= 1'b0;
            r2_spec     <= 1'b0;
            r2_sign     <= 1'b0;
            r2_zsign    <= 1'b0;
            r2_spec_res <= '0;
            r2_spec_flg <= '0;
            r2_exp      <= '0;
            r2_sum      <= '0;
            r2_lzc      <= '0;
        end else if (w_en) begin
            r2_valid    <= r1_valid;
            r2_spec     <= r1_spec;
            r2_sign     <= r1_sign;
            r2_zsign    <= r1_zsign;
            r2_spec_res <= r1_spec_res;
            r2_spec_flg <= r1_spec_flg;
            r2_exp      <= r1_exp;
            r2_sum      <= w_sum;
            r2_lzc      <= w_lzc;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    // The hidden bit sits one below the carry bit, hence the shift of lzc-1.
    logic               w_carry, w_zero, w_g, w_r, w_s, w_rup, w_movf, w_inexact;
    logic [c_lw-1:0]    w_lsh;
    logic [c_mw-1:0]    w_norm;
    logic [c_xw-1:0]    w_exp_n, w_exp_f;
    logic [MAN_W:0]     w_man;
    logic [MAN_W+1:0]   w_mrnd;
    logic [MAN_W-1:0]   w_frac;
    logic               w_ovf, w_unf;
    assign w_carry   = r2_sum[c_sw-1];
    assign w_zero    = ~(|r2_sum);
    assign w_lsh     = r2_lzc - c_lw'(1);
    assign w_norm    = w_carry ? {r2_sum[c_sw-1:2], r2_sum[1] | r2_sum[0]}
                               : c_mw'(r2_sum << w_lsh);
    assign w_exp_n   = w_carry ? (c_xw'(r2_exp) + c_xw'(1))
                               : (c_xw'(r2_exp) - c_xw'(w_lsh));
    assign w_man     = w_norm[c_mw-1:GRS_W];
    assign w_g       = w_norm[2];
    assign w_r       = w_norm[1];
    assign w_s       = w_norm[0];
    assign w_rup     = w_g & (w_r | w_s | w_man[0]);
    assign w_mrnd    = {1'b0, w_man} + (MAN_W+2)'(w_rup);
    assign w_movf    = w_mrnd[MAN_W+1];
    assign w_exp_f   = w_exp_n + c_xw'(w_movf);
    assign w_frac    = w_movf ? w_mrnd[MAN_W:1] : w_mrnd[MAN_W-1:0];
    assign w_inexact = w_g | w_r | w_s;
    assign w_ovf     = $signed(w_exp_f) >= $signed(c_xw'(c_emax));
    assign w_unf     = $signed(w_exp_f) <= $signed(c_xw'(0));

    logic [c_w-1:0]     w_res;
    logic [FLAGS_W-1:0] w_flg;
    always_comb begin
        w_res = {r2_sign, w_exp_f[EXP_W-1:0], w_frac};
        w_flg = '0;
        w_flg[FLG_INEXACT] = w_inexact;
        if (r2_spec) begin
            w_res = r2_spec_res;
            w_flg = r2_spec_flg;
        end else if (w_zero) begin
            w_res = {r2_zsign, {(c_w-1){1'b0}}};
            w_flg = '0;
        end else if (w_ovf) begin
            w_res = {r2_sign, c_emax, {MAN_W{1'b0}}};
            w_flg[FLG_OVF] = 1'b1;
            w_flg[FLG_INEXACT] = 1'b1;
        end else if (w_unf) begin
            w_res = {r2_sign, {(c_w-1){1'b0}}};
            w_flg[FLG_UNF] = 1'b1;
            w_flg[FLG_INEXACT] = 1'b1;
        end
    end

    logic               r3_valid;
    logic [c_w-1:0]     r3_res;
    logic [FLAGS_W-1:0] r3_flg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3_valid <= 1'b0;
            r3_res   <= '0;
            r3_flg   <= '0;
        end else if (w_en) begin
            r3_valid <= r2_valid;
            if (r2_valid) begin
                r3_res <= w_res;
                r3_flg <= w_flg;
            end
        end
    end

    assign bus.out_valid = r3_valid;
    assign bus.result    = r3_res;
    assign bus.flags     = r3_flg;

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fp_addsub_pipe                                                    |
// | Directed vectors for single- and half-width instances of the adder.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fp_addsub_pipe;

    logic clk;
    logic rst_n;

    fp_addsub_pipe_if #(.EXP_W(8), .MAN_W(23)) sp_if ();
    fp_addsub_pipe_if #(.EXP_W(5), .MAN_W(10)) hp_if ();

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) u_sp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sp_if.slave)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) u_hp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hp_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hp;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic void add_v(input logic hp, input logic [31:0] a, input logic [31:0] b,
                                  input logic sub, input logic [31:0] res, input logic [3:0] flg);
        vec_t v;
        v.hp = hp; v.a = a; v.b = b; v.sub = sub; v.res = res; v.flg = flg;
        vecs.push_back(v);
    endfunction

    task automatic run_vec(input int id);
        vec_t        v;
        int          lat;
        logic        got;
        logic [31:0] r;
        logic [3:0]  f;
        v = vecs[id];
        @(negedge clk);
        if (v.hp) begin
            hp_if.a = v.a[15:0]; hp_if.b = v.b[15:0]; hp_if.sub = v.sub; hp_if.in_valid = 1'b1;
        end else begin
            sp_if.a = v.a; sp_if.b = v.b; sp_if.sub = v.sub; sp_if.in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        sp_if.in_valid = 1'b0;
        hp_if.in_valid = 1'b0;
        lat = 1;
        got = v.hp ? hp_if.out_valid : sp_if.out_valid;
        while (!got && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            got = v.hp ? hp_if.out_valid : sp_if.out_valid;
        end
        r = v.hp ? {16'h0, hp_if.result} : sp_if.result;
        f = v.hp ? hp_if.flags : sp_if.flags;
        chk($sformatf("v%0d_out_valid", id), 32'(got), 32'd1);
        chk($sformatf("v%0d_latency", id), 32'(lat), 32'd3);
        chk($sformatf("v%0d_result", id), r, v.res);
        chk($sformatf("v%0d_flags", id), 32'(f), 32'(v.flg));
    endtask

    initial begin
        int sent, rcvd, ready_low, stale;

        rst_n = 1'b0;
        sp_if.in_valid = 1'b0; sp_if.a = '0; sp_if.b = '0; sp_if.sub = 1'b0; sp_if.out_ready = 1'b1;
        hp_if.in_valid = 1'b0; hp_if.a = '0; hp_if.b = '0; hp_if.sub = 1'b0; hp_if.out_ready = 1'b1;

        //        hp    a             b             sub   result        flags
        add_v(1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
        add_v(1'b0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
        add_v(1'b0, 32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 4'b0000);
        add_v(1'b0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
        add_v(1'b0, 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
        add_v(1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
        add_v(1'b0, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
        add_v(1'b0, 32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011);
        add_v(1'b0, 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
        add_v(1'b0, 32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000);
        add_v(1'b0, 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000);
        add_v(1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
        add_v(1'b0, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 4'b0000);
        add_v(1'b0, 32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 4'b0000);
        add_v(1'b0, 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000);
        add_v(1'b0, 32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001);
        add_v(1'b1, 32'h00003C00, 32'h00003C00, 1'b0, 32'h00004000, 4'b0000);
        add_v(1'b1, 32'h00007BFF, 32'h00007BFF, 1'b0, 32'h00007C00, 4'b0101);
        add_v(1'b1, 32'h00003C00, 32'h00003C00, 1'b1, 32'h00000000, 4'b0000);

        #12;
        chk("rst_out_valid", 32'(sp_if.out_valid), 32'd0);
        chk("rst_result", sp_if.result, 32'd0);
        chk("rst_flags", 32'(sp_if.flags), 32'd0);
        chk("rst_in_ready", 32'(sp_if.in_ready), 32'd1);
        chk("rst_hp_out_valid", 32'(hp_if.out_valid), 32'd0);
        chk("rst_hp_result", 32'(hp_if.result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i);
        end

        // Back-to-back issue of the first six vectors under a stalled consumer.
        sent = 0; rcvd = 0; ready_low = 0;
        for (int cyc = 0; cyc < 60 && rcvd < 6; cyc++) begin
            @(negedge clk);
            sp_if.out_ready = !(cyc >= 2 && cyc <= 6);
            sp_if.in_valid  = (sent < 6);
            if (sent < 6) begin
                sp_if.a = vecs[sent].a; sp_if.b = vecs[sent].b; sp_if.sub = vecs[sent].sub;
            end
            #1;
            if (!sp_if.in_ready) ready_low++;
            if (sp_if.out_valid && sp_if.out_ready) begin
                chk($sformatf("bp%0d_result", rcvd), sp_if.result, vecs[rcvd].res);
                chk($sformatf("bp%0d_flags", rcvd), 32'(sp_if.flags), 32'(vecs[rcvd].flg));
                rcvd++;
            end
            if (sp_if.in_valid && sp_if.in_ready) sent++;
        end
        sp_if.in_valid = 1'b0;
        sp_if.out_ready = 1'b1;
        chk("bp_received", 32'(rcvd), 32'd6);
        chk("bp_in_ready_dropped", 32'(ready_low != 0), 32'd1);
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (sp_if.out_valid) stale++;
        end
        chk("bp_no_duplicate", 32'(stale), 32'd0);

        // Reset pulse with results in flight and one waiting at the output.
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            sp_if.out_ready = 1'b0;
            sp_if.in_valid  = 1'b1;
            sp_if.a = vecs[cyc].a; sp_if.b = vecs[cyc].b; sp_if.sub = vecs[cyc].sub;
        end
        @(negedge clk);
        sp_if.in_valid = 1'b0;
        #1;
        chk("rstmid_pre_valid", 32'(sp_if.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_out_valid", 32'(sp_if.out_valid), 32'd0);
        chk("rstmid_result", sp_if.result, 32'd0);
        chk("rstmid_flags", 32'(sp_if.flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sp_if.out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (sp_if.out_valid) stale++;
        end
        chk("rstmid_no_stale", 32'(stale), 32'd0);

        run_vec(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
